// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: op codes, FSM states
// and the iteration counter width.
package mcycle_pkg;

    localparam logic MCYCLE_OP_MUL = 1'b0;
    localparam logic MCYCLE_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mcycle_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mcycle_muldiv_if.sv
// Request/response bundle between the Execute-stage control and mcycle_muldiv.
interface mcycle_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic             MCycleOp;
    logic             Signed;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Signed, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Signed, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_signfix.sv
// Conditional two's-complement negate; yields |x| on operand entry and applies
// the result sign during FIX.
module mcycle_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);
    always_comb begin
        result = negate ? ('0 - value) : value;
    end
endmodule

// File: rtl/mcycle_muldiv.sv
// Iterative multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Optional macro MCYCLE_EARLY_TERM_EN ends a multiply once no multiplier bits remain.
module mcycle_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic            CLK,
    input logic            RESETn,
    mcycle_muldiv_if.slave bus
);
    import mcycle_pkg::*;

    localparam int unsigned CW = cnt_width(WIDTH);

    mcycle_state_e state, state_next;

    logic                 op_q;
    logic                 res_neg;
    logic                 rem_neg;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     shreg;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     result1;
    logic [WIDTH-1:0]     result2;
    logic                 busy;
    logic                 done;
    logic                 last_iter;
    logic                 op2_zero;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   fa_in, fa_out;
    logic [WIDTH-1:0]     fb_in, fb_out;
    logic                 fa_neg, fb_neg;

    assign bus.Result1 = result1;
    assign bus.Result2 = result2;
    assign bus.Busy    = busy;
    assign bus.Done    = done;

    assign op2_zero = (bus.Operand2 == '0);

    // Both helpers are shared: operand magnitudes while idle, result sign fix in FIX.
    always_comb begin
        if (state == FIX) begin
            fa_in  = (op_q == MCYCLE_OP_MUL) ? acc : {{WIDTH{1'b0}}, shreg};
            fa_neg = res_neg;
            fb_in  = rem;
            fb_neg = rem_neg;
        end else begin
            fa_in  = {{WIDTH{1'b0}}, bus.Operand1};
            fa_neg = bus.Signed & bus.Operand1[WIDTH-1];
            fb_in  = bus.Operand2;
            fb_neg = bus.Signed & bus.Operand2[WIDTH-1];
        end
    end

    mcycle_signfix #(.W(2*WIDTH)) u_fix_a (
        .value  (fa_in),
        .negate (fa_neg),
        .result (fa_out)
    );

    mcycle_signfix #(.W(WIDTH)) u_fix_b (
        .value  (fb_in),
        .negate (fb_neg),
        .result (fb_out)
    );

    // Restoring step: the partial remainder needs one extra bit to hold the shifted value.
    always_comb begin
        rem_shift = {rem, shreg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mcand[WIDTH-1:0]};
    end

    always_comb begin
        last_iter = (cnt == CW'(WIDTH - 1));
`ifdef MCYCLE_EARLY_TERM_EN
        if ((op_q == MCYCLE_OP_MUL) && (shreg[WIDTH-1:1] == '0)) begin
            last_iter = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            op_q    <= MCYCLE_OP_MUL;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            shreg   <= '0;
            rem     <= '0;
            result1 <= '0;
            result2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        op_q    <= bus.MCycleOp;
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        res_neg <= bus.Signed
                                 & (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1])
                                 & ~((bus.MCycleOp == MCYCLE_OP_DIV) & op2_zero);
                        rem_neg <= bus.Signed & bus.Operand1[WIDTH-1];
                        cnt     <= '0;
                        acc     <= '0;
                        rem     <= '0;
                        if (bus.MCycleOp == MCYCLE_OP_MUL) begin
                            mcand <= {{WIDTH{1'b0}}, fa_out[WIDTH-1:0]};
                            shreg <= fb_out;
                        end else begin
                            mcand <= {{WIDTH{1'b0}}, fb_out};
                            shreg <= fa_out[WIDTH-1:0];
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (op_q == MCYCLE_OP_MUL) begin
                        if (shreg[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= mcand << 1;
                        shreg <= shreg >> 1;
                    end else begin
                        rem   <= rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                        shreg <= {shreg[WIDTH-2:0], ~rem_diff[WIDTH]};
                    end
                end
                FIX: begin
                    result1 <= fa_out[WIDTH-1:0];
                    result2 <= (op_q == MCYCLE_OP_MUL) ? fa_out[2*WIDTH-1:WIDTH] : fb_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Directed self-checking bench for mcycle_muldiv (WIDTH=32); honours MCYCLE_EARLY_TERM_EN.
module tb_mcycle_muldiv;

    logic CLK;
    logic RESETn;
    int unsigned checks;
    int unsigned errors;

`ifdef MCYCLE_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mcycle_muldiv_if #(.WIDTH(32)) bus ();

    mcycle_muldiv #(.WIDTH(32)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Number of CALC cycles: full width, or up to the top set multiplier bit when terminating early.
    function automatic int unsigned exp_calc(input logic op, input logic sgn, input logic [31:0] b);
        logic [31:0] m;
        int unsigned n_early;
        m = (sgn && b[31]) ? (~b + 32'd1) : b;
        n_early = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (m[i]) n_early = i + 1;
        end
        return (EARLY && (op == 1'b0)) ? n_early : 32;
    endfunction

    task automatic run_op(input string tag, input logic op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e1, input logic [31:0] e2);
        int unsigned busy_cnt;
        int unsigned cyc;
        int unsigned ncalc;
        bit seen;
        ncalc = exp_calc(op, sgn, b);
        bus.MCycleOp = op;
        bus.Signed   = sgn;
        bus.Operand1 = a;
        bus.Operand2 = b;
        bus.Start    = 1'b1;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        busy_cnt = 0;
        cyc      = 1;
        seen     = 1'b0;
        while (!seen && cyc <= 100) begin
            if (bus.Done) begin
                seen = 1'b1;
            end else begin
                if (bus.Busy) busy_cnt++;
                @(posedge CLK); #1;
                cyc++;
            end
        end
        chk({tag, "/done_seen"},   64'(seen), 64'(1));
        chk({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(ncalc + 1));
        chk({tag, "/done_cycle"},  64'(cyc), 64'(ncalc + 2));
        chk({tag, "/busy_at_done"}, 64'(bus.Busy), 64'(0));
        chk({tag, "/result1"}, 64'(bus.Result1), 64'(e1));
        chk({tag, "/result2"}, 64'(bus.Result2), 64'(e2));
        @(posedge CLK); #1;
        chk({tag, "/after_done"}, 64'({bus.Busy, bus.Done}), 64'(0));
        chk({tag, "/hold"}, 64'({bus.Result2, bus.Result1}), {e2, e1});
    endtask

    initial begin
        int unsigned n;
        checks = 0;
        errors = 0;
        RESETn       = 1'b0;
        bus.Start    = 1'b0;
        bus.MCycleOp = 1'b0;
        bus.Signed   = 1'b0;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        #2;
        chk("reset/busy_done", 64'({bus.Busy, bus.Done}), 64'(0));
        chk("reset/results", 64'({bus.Result2, bus.Result1}), 64'(0));
        #10;
        RESETn = 1'b1;
        @(posedge CLK); #1;
        chk("idle/busy_done", 64'({bus.Busy, bus.Done}), 64'(0));

        run_op("umul_max",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("smul_m7x6",  1'b0, 1'b1, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 32'hFFFF_FFFF);
        run_op("sdiv_m7d2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("sdiv_7dm2",  1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_op("udiv_zero",  1'b1, 1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234);
        run_op("sdiv_zero",  1'b1, 1'b1, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234);
        run_op("sdiv_nzero", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_op("sdiv_ovf",   1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("udiv_100d7", 1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
        run_op("smul_minsq", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0,         32'h4000_0000);
        run_op("umul_carry", 1'b0, 1'b0, 32'h8000_0000, 32'd2,         32'd0,         32'd1);

        // Start re-pulsed mid-CALC with new operands, then again in the DONE cycle.
        bus.MCycleOp = 1'b1;
        bus.Signed   = 1'b0;
        bus.Operand1 = 32'd100;
        bus.Operand2 = 32'd7;
        bus.Start    = 1'b1;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        bus.Operand1 = 32'd55;
        bus.Operand2 = 32'd5;
        bus.Start    = 1'b1;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        n = 0;
        while (!bus.Done && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("repulse/done_seen", 64'(bus.Done), 64'(1));
        chk("repulse/done_delay", 64'(n), 64'(28));
        chk("repulse/results", 64'({bus.Result2, bus.Result1}), {32'd2, 32'd14});
        bus.Start = 1'b1;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        chk("repulse/after_done", 64'({bus.Busy, bus.Done}), 64'(0));
        @(posedge CLK); #1;
        chk("repulse/no_queue", 64'({bus.Busy, bus.Done}), 64'(0));

        // Asynchronous reset in the middle of CALC.
        bus.MCycleOp = 1'b0;
        bus.Signed   = 1'b0;
        bus.Operand1 = 32'h1234_5678;
        bus.Operand2 = 32'h0000_0010;
        bus.Start    = 1'b1;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("midreset/busy_before", 64'(bus.Busy), 64'(1));
        RESETn = 1'b0;
        #1;
        chk("midreset/busy_done", 64'({bus.Busy, bus.Done}), 64'(0));
        chk("midreset/results", 64'({bus.Result2, bus.Result1}), 64'(0));
        #3;
        RESETn = 1'b1;
        @(posedge CLK); #1;
        chk("midreset/idle", 64'({bus.Busy, bus.Done}), 64'(0));
        run_op("umul_after_rst", 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'd1);

        run_op("umul_5x3", 1'b0, 1'b0, 32'd5, 32'd3, 32'd15, 32'd0);
        run_op("umul_x0",  1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
